// File: rtl/reset_seq_pkg.sv
// Shared definitions for the staged reset sequencer: FSM state encoding,
// default timing constants and the stage-index width helper.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_RELEASE  = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_DELAY    = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERROR    = 3'd5
  } seq_state_t;

  localparam int DEF_NUM_STAGES  = 3;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_STAGE_DELAY = 8;
  localparam int DEF_ACK_TIMEOUT = 255;
  localparam int CNT_W           = 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Saturating 8-bit cycle counter with clear, enable and an equality
// terminal-count compare against a caller-supplied last value.
module cycle_timer
  import reset_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] last,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // clr together with en restarts the count with the current cycle already
  // counted, so a window can begin on the same edge that opens it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= en ? CNT_W'(1) : '0;
    end else if (en && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == last);

endmodule

// File: rtl/reset_sequencer.sv
// Releases downstream reset stages one at a time, waiting for each stage's
// ack, with an ack timeout that parks the block in ERROR until a restart.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int STAGE_DELAY = DEF_STAGE_DELAY,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  power_on_reset,
  input  logic                  sw_reset_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  seq_done,
  output logic                  seq_error,
  output logic [2:0]            seq_state
);

  localparam int IDX_W = idx_width(NUM_STAGES);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(STAGE_DELAY - 1);

  seq_state_t       state;
  logic [IDX_W-1:0] idx;
  logic             restart;
  logic             ack_sel;
  logic             tmr_clr;
  logic             tmr_en;
  logic             tmr_tc;
  logic [CNT_W-1:0] tmr_last;

  function automatic logic [NUM_STAGES-1:0] stage_mask(input logic [IDX_W-1:0] sel);
    logic [NUM_STAGES-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (sel == IDX_W'(i)) m[i] = 1'b1;
    end
    return m;
  endfunction

  assign restart   = power_on_reset | sw_reset_req;
  assign ack_sel   = |(stage_ack & stage_mask(idx));
  assign seq_state = state;

  // The ack edge counts as the first cycle of the inter-stage delay window.
  always_comb begin
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    tmr_last = HOLD_LAST;
    if (restart) begin
      tmr_clr = 1'b1;
    end else begin
      case (state)
        ST_HOLD: begin
          tmr_en   = 1'b1;
          tmr_last = HOLD_LAST;
        end
        ST_WAIT_ACK: begin
          tmr_en   = 1'b1;
          tmr_clr  = ack_sel;
          tmr_last = ACK_LAST;
        end
        ST_DELAY: begin
          tmr_en   = 1'b1;
          tmr_last = DELAY_LAST;
        end
        default: tmr_clr = 1'b1;
      endcase
    end
  end

  cycle_timer u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .last  (tmr_last),
    .tc    (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_HOLD;
      idx         <= '0;
      stage_reset <= '1;
      seq_done    <= 1'b0;
      seq_error   <= 1'b0;
    end else if (restart) begin
      state       <= ST_HOLD;
      idx         <= '0;
      stage_reset <= '1;
      seq_done    <= 1'b0;
      seq_error   <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (tmr_tc) begin
            state <= ST_RELEASE;
            idx   <= '0;
          end
        end
        ST_RELEASE: begin
          stage_reset <= stage_reset & ~stage_mask(idx);
          state       <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          // An ack in the timeout cycle still wins.
          if (ack_sel) begin
            if (idx == LAST_IDX) begin
              state    <= ST_DONE;
              seq_done <= 1'b1;
            end else if (DELAY_LAST == '0) begin
              idx   <= idx + IDX_W'(1);
              state <= ST_RELEASE;
            end else begin
              state <= ST_DELAY;
            end
          end else if (tmr_tc) begin
            state       <= ST_ERROR;
            seq_error   <= 1'b1;
            stage_reset <= '1;
          end
        end
        ST_DELAY: begin
          if (tmr_tc) begin
            idx   <= idx + IDX_W'(1);
            state <= ST_RELEASE;
          end
        end
        ST_DONE: begin
          seq_done    <= 1'b1;
          stage_reset <= '0;
        end
        ST_ERROR: begin
          seq_error   <= 1'b1;
          stage_reset <= '1;
        end
        default: begin
          state       <= ST_HOLD;
          idx         <= '0;
          stage_reset <= '1;
          seq_done    <= 1'b0;
          seq_error   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters; edge numbers
// count posedges from the first edge that samples the new input condition.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       power_on_reset;
  logic       sw_reset_req;
  logic [2:0] stage_ack;
  logic [2:0] stage_reset;
  logic       seq_done;
  logic       seq_error;
  logic [2:0] seq_state;

  int checks;
  int errors;
  int e;

  reset_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .power_on_reset (power_on_reset),
    .sw_reset_req   (sw_reset_req),
    .stage_ack      (stage_ack),
    .stage_reset    (stage_reset),
    .seq_done       (seq_done),
    .seq_error      (seq_error),
    .seq_state      (seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  // Hold power_on_reset for two edges, then drop it; the next tick is edge 1.
  task automatic start_seq();
    power_on_reset = 1'b1;
    tick();
    tick();
    power_on_reset = 1'b0;
    e = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    e = 0;
    rst_n = 1'b1;
    power_on_reset = 1'b1;
    sw_reset_req = 1'b0;
    stage_ack = 3'b000;
    #1 rst_n = 1'b0;
    #1;
    check("rst_stage_reset", stage_reset, 3'b111);
    check("rst_done", seq_done, 0);
    check("rst_error", seq_error, 0);
    check("rst_state", seq_state, ST_HOLD);
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal sequence with all acks high.
    stage_ack = 3'b111;
    start_seq();
    while (e < 36) begin
      tick();
      if (e == 16) check("a_hold16", stage_reset, 3'b111);
      if (e == 17) check("a_rel0", stage_reset, 3'b110);
      if (e == 17) check("a_st_wait", seq_state, ST_WAIT_ACK);
      if (e == 18) check("a_st_delay", seq_state, ST_DELAY);
      if (e == 25) check("a_pre1", stage_reset, 3'b110);
      if (e == 26) check("a_rel1", stage_reset, 3'b100);
      if (e == 34) check("a_pre2", stage_reset, 3'b100);
      if (e == 35) check("a_rel2", stage_reset, 3'b000);
      if (e == 35) check("a_done35", seq_done, 0);
      if (e == 36) check("a_done36", seq_done, 1);
      if (e == 36) check("a_st_done", seq_state, ST_DONE);
    end
    stage_ack = 3'b000;
    tick();
    check("a_done_hold", seq_done, 1);
    check("a_done_rst", stage_reset, 3'b000);
    // power_on_reset reasserted in DONE.
    power_on_reset = 1'b1;
    tick();
    check("por_done", seq_done, 0);
    check("por_rst", stage_reset, 3'b111);
    check("por_state", seq_state, ST_HOLD);

    // Ack timeout on stage 0.
    stage_ack = 3'b000;
    start_seq();
    while (e < 272) begin
      tick();
      if (e == 271) check("b_st271", seq_state, ST_WAIT_ACK);
      if (e == 271) check("b_err271", seq_error, 0);
    end
    check("b_st_err", seq_state, ST_ERROR);
    check("b_err", seq_error, 1);
    check("b_rst", stage_reset, 3'b111);
    check("b_done", seq_done, 0);
    stage_ack = 3'b111;
    tick();
    check("b_err_stays", seq_state, ST_ERROR);
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    check("b_sw_state", seq_state, ST_HOLD);
    check("b_sw_err", seq_error, 0);

    // Software restart during DELAY, then full rerun.
    stage_ack = 3'b111;
    start_seq();
    while (e < 20) tick();
    check("c_in_delay", seq_state, ST_DELAY);
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    check("c_sw_rst", stage_reset, 3'b111);
    check("c_sw_state", seq_state, ST_HOLD);
    e = 0;
    while (e < 36) begin
      tick();
      if (e == 16) check("c_hold16", stage_reset, 3'b111);
      if (e == 17) check("c_rel0", stage_reset, 3'b110);
      if (e == 26) check("c_rel1", stage_reset, 3'b100);
      if (e == 35) check("c_rel2", stage_reset, 3'b000);
      if (e == 36) check("c_done", seq_done, 1);
    end

    // Acks on the wrong stage are ignored.
    stage_ack = 3'b100;
    start_seq();
    while (e < 30) tick();
    check("d_wait0", seq_state, ST_WAIT_ACK);
    check("d_rst0", stage_reset, 3'b110);
    stage_ack = 3'b101;
    while (e < 50) begin
      tick();
      if (e == 38) check("d_pre1", stage_reset, 3'b110);
      if (e == 39) check("d_rel1", stage_reset, 3'b100);
    end
    check("d_wait1", seq_state, ST_WAIT_ACK);
    check("d_rst1", stage_reset, 3'b100);
    stage_ack = 3'b011;
    tick();
    check("d_to_delay", seq_state, ST_DELAY);
    stage_ack = 3'b000;
    while (e < 60) begin
      tick();
      if (e == 59) check("d_rel2", stage_reset, 3'b000);
    end
    check("d_no_done", seq_done, 0);
    check("d_wait2", seq_state, ST_WAIT_ACK);
    check("d_kept", stage_reset, 3'b000);

    // Asynchronous rst_n mid WAIT_ACK.
    stage_ack = 3'b000;
    start_seq();
    while (e < 20) tick();
    check("e_wait", stage_reset, 3'b110);
    #2 rst_n = 1'b0;
    #1;
    check("e_async_rst", stage_reset, 3'b111);
    check("e_async_state", seq_state, ST_HOLD);
    check("e_async_done", seq_done, 0);
    #2 rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog at edge %0d: got timeout expected finish", e);
    $fatal(1);
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3: number of staged reset outputs (range 1..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: cycles all stages stay in reset after power_on_reset deasserts (range 1..255).
REQ-003 SHALL have parameter STAGE_DELAY, default 8: cycles between an ack and the next stage's release (range 1..255).
REQ-004 SHALL have parameter ACK_TIMEOUT, default 255: maximum cycles to wait for a stage ack (range 1..255).
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port power_on_reset, input, 1: active-high synchronous power-on reset from the upstream generator, synchronous to clk.
REQ-008 SHALL have port sw_reset_req, input, 1: single-cycle software restart request, synchronous to clk.
REQ-009 SHALL have port stage_ack, input, NUM_STAGES: per-stage ready/lock indication, synchronous to clk.
REQ-010 SHALL have port stage_reset, output, NUM_STAGES: active-high reset for each downstream stage.
REQ-011 SHALL have port seq_done, output, 1: high when all stages are released and acknowledged.
REQ-012 SHALL have port seq_error, output, 1: high when an ack timeout has occurred.
REQ-013 SHALL have port seq_state, output, 3: current FSM state encoding, for status readback.

Function
REQ-014 SHALL implement the FSM states HOLD, RELEASE, WAIT_ACK, DELAY, DONE and ERROR, with a stage index idx of width clog2(NUM_STAGES) (minimum 1).
REQ-015 HOLD: SHALL clear the counter while power_on_reset=1, and count while power_on_reset=0; on reaching HOLD_CYCLES-1 it SHALL go to RELEASE with idx=0.
REQ-016 RELEASE: SHALL register stage_reset[idx]<=0 for one cycle, then go to WAIT_ACK with the counter cleared.
REQ-017 WAIT_ACK: SHALL sample only stage_ack[idx]; acks on other bits SHALL be ignored.
REQ-018 WAIT_ACK: if stage_ack[idx]=1 and idx=NUM_STAGES-1, SHALL go to DONE; if stage_ack[idx]=1 otherwise, SHALL go to DELAY.
REQ-019 WAIT_ACK: if the counter reaches ACK_TIMEOUT-1 without an ack, SHALL go to ERROR; an ack in the timeout cycle wins over the timeout.
REQ-020 DELAY: SHALL count STAGE_DELAY cycles, then increment idx and go to RELEASE.
REQ-021 Latency: stage_reset[0] SHALL fall exactly HOLD_CYCLES+1 edges after the first edge sampling power_on_reset=0; stage_reset[k+1] SHALL fall exactly STAGE_DELAY+1 edges after the edge sampling stage_ack[k]=1.
REQ-022 Once released, a stage SHALL stay released until a restart, regardless of later ack deassertion.
REQ-023 DONE: SHALL hold seq_done=1 and stage_reset=0 for all stages.
REQ-024 ERROR: SHALL hold seq_error=1, reassert all stage_reset bits, and remain until a restart.
REQ-025 Restart: power_on_reset=1 or sw_reset_req=1 in any state SHALL force HOLD on the next edge, with all stage_reset=1, seq_done=0, seq_error=0, idx=0 and the counter at 0; restart SHALL take priority over ack and timeout in the same cycle.
REQ-026 All outputs SHALL be registered, with no combinational path from input to output.
REQ-027 Counters SHALL be 8-bit and SHALL never wrap; every compare SHALL be an equality against the parameter minus 1.

Reset
REQ-028 While rst_n=0, SHALL hold state=HOLD, stage_reset=all ones, seq_done=0, seq_error=0, counter=0 and idx=0, asynchronously.
REQ-029 rst_n deassertion SHALL take effect at the next clk edge; sequencing then SHALL also wait for power_on_reset=0.

Structure
REQ-030 The state encoding and the default parameter constants SHALL live in shared package reset_seq_pkg.
REQ-031 The cycle counting (clear, enable, terminal-count compare) SHALL be one sub-module, cycle_timer, reused by HOLD, WAIT_ACK and DELAY.

Verification (defaults)
REQ-032 power_on_reset falls with stage_ack tied to all ones -> stage_reset[0] falls at edge 17, [1] at 26, [2] at 35, and seq_done=1 at edge 36.
REQ-033 stage_ack[0] is withheld -> at edge 255 in WAIT_ACK the block enters ERROR, seq_error=1, stage_reset=3'b111 and seq_done stays 0.
REQ-034 sw_reset_req is pulsed in DELAY after stage 0 is released -> next edge stage_reset=3'b111 and state=HOLD; the sequence then reruns (power_on_reset low) with the REQ-032 timing.
REQ-035 stage_ack[2] is high early while idx=0 -> it is ignored and stage 1 still waits for its own ack.
REQ-036 rst_n pulses low mid-WAIT_ACK -> outputs return to reset values immediately, without waiting for clk.
REQ-037 power_on_reset reasserts in DONE -> next edge seq_done=0 and all stage_reset=1.
